sos_stream_driver: RTL and testbench

- Upstream-side initiator for one biquad (SOS) section.
- Accepts 24-bit samples over a valid/ready stream and buffers them.
- Issues one sample at a time as a single-cycle sos_valid_in pulse, with the active coefficient set, then waits for sos_valid_out, captures sos_data_out and presents it downstream over valid/ready.
- Enforces one-outstanding-sample spacing so the section's feedback path is always settled. Owns shadow/active coefficient registers.

---
 rtl/sos_pkg.sv | 24 ++
 rtl/sos_sync_fifo.sv | 58 +++++
 rtl/sos_stream_driver.sv | 180 ++++++++++++++++++
 tb/tb_sos_stream_driver.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sos_pkg.sv
// Shared constants and types for the biquad section stream driver.
// Coefficient addresses map straight onto the shadow/active register index.
package sos_pkg;

    localparam int DW     = 24;
    localparam int N_COEF = 5;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    function automatic logic is_coef_addr(input logic [2:0] addr);
        return addr <= COEF_A2;
    endfunction

endpackage

// File: rtl/sos_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count and a fall-through head.
// Pushes into a full FIFO are refused even if a pop happens in the same cycle.
module sos_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sos_stream_driver.sv
// Feeds one biquad section a sample at a time from an input FIFO and returns its results
// through a 2-entry output buffer; owns the shadow/active coefficient registers.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for work; applies a pending coefficient commit first
// S_ISSUE | one-cycle sos_valid_in pulse, pops the input FIFO
// S_WAIT  | sample outstanding; waits for sos_valid_out or the timeout
module sos_stream_driver
    import sos_pkg::*;
#(
    parameter int DW         = sos_pkg::DW,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic [DW-1:0] sos_data_in,
    output logic          sos_valid_in,
    output logic [DW-1:0] sos_b0,
    output logic [DW-1:0] sos_b1,
    output logic [DW-1:0] sos_b2,
    output logic [DW-1:0] sos_a1,
    output logic [DW-1:0] sos_a2,
    input  logic [DW-1:0] sos_data_out,
    input  logic          sos_valid_out,
    output logic          busy,
    output logic          err
);

    localparam int ICW       = $clog2(FIFO_DEPTH + 1);
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam int OUT_DEPTH = 2;

    state_t         state;
    state_t         state_next;
    logic [ICW-1:0] in_count;
    logic [DW-1:0]  in_head;
    logic           in_pop;
    logic           in_full;
    logic [1:0]     out_count;
    logic           out_push;
    logic [TW-1:0]  wait_cnt;
    logic           commit_pend;
    logic           do_commit;
    logic           timeout_hit;
    logic           stray_strobe;
    logic [DW-1:0]  shadow [N_COEF];
    logic [DW-1:0]  active [N_COEF];

    assign in_full = (in_count == ICW'(FIFO_DEPTH));
    assign s_ready = !in_full;

    sos_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (in_pop),
        .head      (in_head),
        .count     (in_count)
    );

    sos_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (OUT_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (out_push),
        .push_data (sos_data_out),
        .pop       (m_valid && m_ready),
        .head      (m_data),
        .count     (out_count)
    );

    assign m_valid      = (out_count != 2'd0);
    assign sos_valid_in = (state == S_ISSUE);
    assign busy         = (state != S_IDLE) || (in_count != '0) || commit_pend;
    assign stray_strobe = sos_valid_out && (state != S_WAIT);

    // A commit blocks issue so coefficients only ever change with nothing in flight.
    always_comb begin
        state_next  = state;
        in_pop      = 1'b0;
        out_push    = 1'b0;
        do_commit   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (commit_pend) begin
                    do_commit = 1'b1;
                end else if ((in_count != '0) && (out_count < 2'd2)) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                in_pop     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (sos_valid_out) begin
                    out_push   = 1'b1;
                    state_next = S_IDLE;
                end else if (wait_cnt == '0) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            sos_data_in <= '0;
            err         <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_ISSUE) begin
                wait_cnt <= TW'(TIMEOUT - 1);
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if ((state == S_IDLE) && (state_next == S_ISSUE)) begin
                sos_data_in <= in_head;
            end
            if (timeout_hit || stray_strobe) begin
                err <= 1'b1;
            end
            if (cfg_commit) begin
                commit_pend <= 1'b1;
            end else if (do_commit) begin
                commit_pend <= 1'b0;
            end
        end
    end

    // Nonblocking copy means a same-cycle cfg_we lands after the commit snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COEF; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (cfg_we && is_coef_addr(cfg_addr)) begin
                shadow[cfg_addr] <= cfg_wdata;
            end
            if (do_commit) begin
                for (int i = 0; i < N_COEF; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    assign sos_b0 = active[COEF_B0];
    assign sos_b1 = active[COEF_B1];
    assign sos_b2 = active[COEF_B2];
    assign sos_a1 = active[COEF_A1];
    assign sos_a2 = active[COEF_A2];

endmodule

// File: tb/tb_sos_stream_driver.sv
// Directed bench for sos_stream_driver with an echo stub standing in for the biquad section.
// Issued and returned samples are tracked in queues filled as stimulus is driven.
`timescale 1ns/1ps
module tb_sos_stream_driver;

    localparam int STUB_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic        cfg_commit;
    logic [23:0] sos_data_in;
    logic        sos_valid_in;
    logic [23:0] sos_b0, sos_b1, sos_b2, sos_a1, sos_a2;
    logic [23:0] sos_data_out  = '0;
    logic        sos_valid_out = 1'b0;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_iss = -1;
    int          n_issues = 0;
    logic [23:0] iss_q [$];
    logic [23:0] exp_q [$];
    logic [23:0] exp_b0 = '0;
    logic [23:0] exp_a1 = '0;

    bit          stub_en   = 1'b1;
    int          stub_cnt  = 0;
    logic [23:0] stub_data = '0;

    int          stalls;
    int          refused;
    int          base_iss;

    sos_stream_driver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_commit    (cfg_commit),
        .sos_data_in   (sos_data_in),
        .sos_valid_in  (sos_valid_in),
        .sos_b0        (sos_b0),
        .sos_b1        (sos_b1),
        .sos_b2        (sos_b2),
        .sos_a1        (sos_a1),
        .sos_a2        (sos_a2),
        .sos_data_out  (sos_data_out),
        .sos_valid_out (sos_valid_out),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Echo stub: returns the issued sample STUB_LAT cycles after the issue pulse; ignores reset.
    always @(posedge clk) begin
        sos_valid_out <= 1'b0;
        if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                sos_valid_out <= 1'b1;
                sos_data_out  <= stub_data;
            end
        end else if (sos_valid_in && stub_en) begin
            stub_cnt  <= STUB_LAT;
            stub_data <= sos_data_in;
        end
    end

    always @(negedge clk) begin
        if (rst_n && sos_valid_in) begin
            n_checks++;
            assert (iss_q.size() != 0) else begin
                n_fail++;
                $error("FAIL issue_unexpected: observed data 0x%0h with no sample queued", sos_data_in);
            end
            if (iss_q.size() != 0) check("issue_data", 32'(sos_data_in), 32'(iss_q.pop_front()));
            check("issue_b0", 32'(sos_b0), 32'(exp_b0));
            check("issue_a1", 32'(sos_a1), 32'(exp_a1));
            if (last_iss >= 0) check("issue_spacing_ge5", 32'(cyc - last_iss >= 5), 32'd1);
            last_iss = cyc;
            n_issues++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL out_unexpected: observed 0x%0h with nothing expected", m_data);
            end
            if (exp_q.size() != 0) check("out_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, required end within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic push_sample(input logic [23:0] d, input bit completes, output int n_stall);
        bit taken;
        taken   = 1'b0;
        n_stall = 0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 300 && !taken; i++) begin
            taken = s_ready;
            if (!taken) n_stall++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("push_accept", 32'(taken), 32'd1);
        if (taken) begin
            iss_q.push_back(d);
            if (completes) exp_q.push_back(d);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [23:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = sos_valid_in;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_strobe(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = sos_valid_out;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && !m_valid;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        s_data     = '0;
        s_valid    = 1'b0;
        m_ready    = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_commit = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_sos_valid_in", 32'(sos_valid_in), 32'd0);
        check("rst_sos_data_in", 32'(sos_data_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_b0", 32'(sos_b0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Coefficient commit and first sample through the echo stub.
        cfg_write(3'd0, 24'h400000);
        check("b0_before_commit", 32'(sos_b0), 32'd0);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("busy_commit_pend", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        check("b0_after_commit", 32'(sos_b0), 32'h400000);
        check("idle_not_busy", 32'(busy), 32'd0);
        exp_b0 = 24'h400000;

        push_sample(24'h000100, 1'b1, stalls);
        wait_issue("t1_issue_seen");
        wait_strobe("t1_strobe_seen");
        check("t1_m_valid_at_strobe", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("t1_m_valid_after", 32'(m_valid), 32'd1);
        check("t1_m_data", 32'(m_data), 32'h000100);
        drain("t1_drain");

        // Burst of six with the consumer always ready.
        refused = 0;
        for (int v = 1; v <= 6; v++) begin
            push_sample(24'(v), 1'b1, stalls);
            refused += stalls;
        end
        check("burst_s_ready_dropped", 32'(refused > 0), 32'd1);
        drain("burst_drain");

        // Consumer stalled: only two samples may be issued into the output buffer.
        m_ready  = 1'b0;
        base_iss = n_issues;
        for (int v = 0; v < 4; v++) begin
            push_sample(24'h000010 + 24'(v), 1'b1, stalls);
        end
        repeat (40) @(negedge clk);
        check("stall_issue_count", 32'(n_issues - base_iss), 32'd2);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_m_data", 32'(m_data), 32'h000010);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_s_ready", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        drain("stall_drain");

        // Section never answers: WAIT lasts TIMEOUT cycles, sample dropped.
        stub_en = 1'b0;
        push_sample(24'h0bad00, 1'b0, stalls);
        wait_issue("to_issue_seen");
        check("to_err_at_issue", 32'(err), 32'd0);
        repeat (16) @(negedge clk);
        check("to_err_last_wait", 32'(err), 32'd0);
        @(negedge clk);
        check("to_err_set", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_dropped", 32'(m_valid), 32'd0);
        stub_en = 1'b1;
        push_sample(24'h00c0de, 1'b1, stalls);
        drain("to_next_drain");

        // Commit requested mid-WAIT takes effect only after return to IDLE.
        cfg_write(3'd3, 24'h123456);
        check("a1_shadow_only", 32'(sos_a1), 32'd0);
        push_sample(24'h0abcde, 1'b1, stalls);
        wait_issue("cw_issue_seen");
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("cw_a1_wait", 32'(sos_a1), 32'd0);
        wait_strobe("cw_strobe_seen");
        check("cw_a1_strobe", 32'(sos_a1), 32'd0);
        @(negedge clk);
        check("cw_a1_idle", 32'(sos_a1), 32'd0);
        check("cw_busy_pend", 32'(busy), 32'd1);
        @(negedge clk);
        check("cw_a1_committed", 32'(sos_a1), 32'h123456);
        exp_a1 = 24'h123456;
        push_sample(24'hfedcba, 1'b1, stalls);
        drain("cw_drain");

        // Reset mid-WAIT; the stub's late strobe must flag err.
        push_sample(24'h055555, 1'b0, stalls);
        wait_issue("rw_issue_seen");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw_s_ready", 32'(s_ready), 32'd1);
        check("rw_m_valid", 32'(m_valid), 32'd0);
        check("rw_sos_valid_in", 32'(sos_valid_in), 32'd0);
        check("rw_sos_data_in", 32'(sos_data_in), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_err", 32'(err), 32'd0);
        check("rw_b0", 32'(sos_b0), 32'd0);
        check("rw_a1", 32'(sos_a1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rw_late_err", 32'(err), 32'd1);
        check("rw_fifo_empty", 32'(busy), 32'd0);
        check("rw_no_output", 32'(m_valid), 32'd0);

        check("iss_q_empty", 32'(iss_q.size()), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
